// File: rtl/hist_stream_packer_pkg.sv
// Shared definitions for the histogram stream packer.
// Holds the default header/trailer tags, the field widths of the packed 32-bit
// output word (tag or data in the upper half, data in the lower half) and the
// FSM state encoding.
package hist_stream_packer_pkg;

    localparam int unsigned TAG_W  = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned WORD_W = TAG_W + DATA_W;

    localparam logic [TAG_W-1:0] HDR_TAG_DEF = 16'hA5A5;
    localparam logic [TAG_W-1:0] TRL_TAG_DEF = 16'h5A5A;

    typedef enum logic [1:0] {
        StHdr  = 2'd0,
        StLo   = 2'd1,
        StHi   = 2'd2,
        StMode = 2'd3
    } state_e;

endpackage

// File: rtl/hist_stream_packer.sv
// Packs the histogram core's 16-bit frequency and mode ap_fifo streams into
// framed 32-bit words: one header {HDR_TAG, frame_count}, NUM_BINS/2 bin-pair
// words {odd bin, even bin} and one trailer {TRL_TAG, mode}.
//
// Ports:
//   ap_clk, ap_rst           clock, synchronous active-high reset
//   freq_din/write/full_n    bin frequency stream from the core
//   mode_din/write/full_n    mode stream from the core
//   out_din/wr_en/full       packed word stream into the CDC FIFO
//   frame_count              completed frames (wraps), header uses this value
//   last_total               sum of all bins of the last completed frame
//   proto_err                sticky: a write strobe arrived while its full_n=0
module hist_stream_packer
    import hist_stream_packer_pkg::*;
#(
    parameter int unsigned       NUM_BINS = 64,
    parameter logic [TAG_W-1:0]  HDR_TAG  = HDR_TAG_DEF,
    parameter logic [TAG_W-1:0]  TRL_TAG  = TRL_TAG_DEF
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [DATA_W-1:0] freq_din,
    input  logic              freq_write,
    output logic              freq_full_n,
    input  logic [DATA_W-1:0] mode_din,
    input  logic              mode_write,
    output logic              mode_full_n,
    output logic [WORD_W-1:0] out_din,
    output logic              out_wr_en,
    input  logic              out_full,
    output logic [15:0]       frame_count,
    output logic [31:0]       last_total,
    output logic              proto_err
);

    localparam int unsigned CntW = $clog2(NUM_BINS + 1);

    state_e              state_q;
    logic [DATA_W-1:0]   lo_q;
    logic [CntW-1:0]     bin_cnt_q;
    logic [31:0]         run_sum_q;
    logic [15:0]         frame_count_q;
    logic [31:0]         last_total_q;
    logic                proto_err_q;

    logic                freq_acc;
    logic                mode_acc;
    logic                strobe_viol;
    logic                last_pair;

    assign last_pair = (32'(bin_cnt_q) + 32'd2) == NUM_BINS;

    // Handshake and FIFO write are combinational so a word moves in the same
    // cycle the core's strobe is accepted.
    always_comb begin
        freq_full_n = 1'b0;
        mode_full_n = 1'b0;
        out_wr_en   = 1'b0;
        out_din     = '0;
        if (!ap_rst) begin
            unique case (state_q)
                StHdr: begin
                    out_wr_en = !out_full;
                    out_din   = {HDR_TAG, frame_count_q};
                end
                // Low half only goes into lo_q, so it is accepted even while
                // the FIFO is full.
                StLo: begin
                    freq_full_n = 1'b1;
                end
                StHi: begin
                    freq_full_n = !out_full;
                    out_wr_en   = freq_write && !out_full;
                    out_din     = {freq_din, lo_q};
                end
                StMode: begin
                    mode_full_n = !out_full;
                    out_wr_en   = mode_write && !out_full;
                    out_din     = {TRL_TAG, mode_din};
                end
                default: ;
            endcase
        end
    end

    assign freq_acc    = freq_write && freq_full_n;
    assign mode_acc    = mode_write && mode_full_n;
    assign strobe_viol = (freq_write && !freq_full_n) || (mode_write && !mode_full_n);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q       <= StHdr;
            lo_q          <= '0;
            bin_cnt_q     <= '0;
            run_sum_q     <= '0;
            frame_count_q <= '0;
            last_total_q  <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            proto_err_q <= proto_err_q || strobe_viol;
            unique case (state_q)
                StHdr: begin
                    if (!out_full) begin
                        bin_cnt_q <= '0;
                        run_sum_q <= '0;
                        state_q   <= StLo;
                    end
                end
                StLo: begin
                    if (freq_acc) begin
                        lo_q      <= freq_din;
                        run_sum_q <= run_sum_q + 32'(freq_din);
                        state_q   <= StHi;
                    end
                end
                StHi: begin
                    if (freq_acc) begin
                        run_sum_q <= run_sum_q + 32'(freq_din);
                        bin_cnt_q <= bin_cnt_q + CntW'(2);
                        state_q   <= last_pair ? StMode : StLo;
                    end
                end
                StMode: begin
                    if (mode_acc) begin
                        last_total_q  <= run_sum_q;
                        frame_count_q <= frame_count_q + 16'd1;
                        state_q       <= StHdr;
                    end
                end
                default: state_q <= StHdr;
            endcase
        end
    end

    assign frame_count = frame_count_q;
    assign last_total  = last_total_q;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_hist_stream_packer.sv
module tb_hist_stream_packer;

    localparam int unsigned NB = 4;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [15:0] freq_din;
    logic        freq_write;
    logic        freq_full_n;
    logic [15:0] mode_din;
    logic        mode_write;
    logic        mode_full_n;
    logic [31:0] out_din;
    logic        out_wr_en;
    logic        out_full;
    logic [15:0] frame_count;
    logic [31:0] last_total;
    logic        proto_err;

    always #5 ap_clk = ~ap_clk;

    hist_stream_packer #(.NUM_BINS(NB)) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .freq_din    (freq_din),
        .freq_write  (freq_write),
        .freq_full_n (freq_full_n),
        .mode_din    (mode_din),
        .mode_write  (mode_write),
        .mode_full_n (mode_full_n),
        .out_din     (out_din),
        .out_wr_en   (out_wr_en),
        .out_full    (out_full),
        .frame_count (frame_count),
        .last_total  (last_total),
        .proto_err   (proto_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: expected word stream built frame by frame.
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    logic [15:0] bin_q [$];
    logic [15:0] mode_q [$];
    logic [15:0] m_fc;
    logic [31:0] m_total;
    int          bins_acc;
    int          wr_while_full;
    logic        obs_ffn;
    logic        obs_wr;

    task automatic queue_frame(input logic [15:0] b0, input logic [15:0] b1,
                               input logic [15:0] b2, input logic [15:0] b3,
                               input logic [15:0] md);
        exp_q.push_back({16'hA5A5, m_fc});
        exp_q.push_back({b1, b0});
        exp_q.push_back({b3, b2});
        exp_q.push_back({16'h5A5A, md});
        m_total = 32'(b0) + 32'(b1) + 32'(b2) + 32'(b3);
        m_fc    = m_fc + 16'd1;
        bin_q.push_back(b0);
        bin_q.push_back(b1);
        bin_q.push_back(b2);
        bin_q.push_back(b3);
        mode_q.push_back(md);
    endtask

    // One cycle of an ap_fifo producer plus FIFO-side monitor.
    task automatic step(input logic of, input logic fw_force);
        @(negedge ap_clk);
        out_full = of;
        #1;
        freq_write = fw_force || ((bin_q.size() != 0) && freq_full_n);
        freq_din   = (bin_q.size() != 0) ? bin_q[0] : 16'($urandom);
        mode_write = (mode_q.size() != 0) && mode_full_n;
        mode_din   = (mode_q.size() != 0) ? mode_q[0] : 16'($urandom);
        #1;
        obs_ffn = freq_full_n;
        obs_wr  = out_wr_en;
        if (out_wr_en) begin
            got_q.push_back(out_din);
            if (out_full) wr_while_full++;
        end
        if (freq_write && freq_full_n && bin_q.size() != 0) begin
            void'(bin_q.pop_front());
            bins_acc++;
        end
        if (mode_write && mode_full_n) void'(mode_q.pop_front());
    endtask

    task automatic drain(input int full_pct, output int cycles, output bit timeout);
        cycles = 0;
        while ((bin_q.size() != 0 || mode_q.size() != 0) && cycles < 500) begin
            step(32'($urandom_range(99, 0)) < full_pct, 1'b0);
            cycles++;
        end
        timeout = (bin_q.size() != 0 || mode_q.size() != 0);
        // Let the trailer edge land while holding off the next header.
        step(1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst     = 1'b1;
        freq_write = 1'b0;
        mode_write = 1'b0;
        out_full   = 1'b0;
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst   = 1'b0;
        out_full = 1'b1;
        exp_q.delete();
        got_q.delete();
        bin_q.delete();
        mode_q.delete();
        m_fc     = '0;
        m_total  = '0;
        bins_acc = 0;
    endtask

    task automatic test_reset();
        @(negedge ap_clk);
        ap_rst     = 1'b1;
        out_full   = 1'b0;
        freq_write = 1'b1;
        mode_write = 1'b1;
        freq_din   = 16'h1234;
        mode_din   = 16'h4321;
        @(negedge ap_clk);
        #1;
        n_cmp++;
        if (out_wr_en !== 1'b0) begin
            n_err++; $display("FAIL rst_wr_en got %b want 0", out_wr_en);
        end
        n_cmp++;
        if ({freq_full_n, mode_full_n} !== 2'b00) begin
            n_err++; $display("FAIL rst_full_n got %b want 00", {freq_full_n, mode_full_n});
        end
        @(negedge ap_clk);
        ap_rst     = 1'b0;
        freq_write = 1'b0;
        mode_write = 1'b0;
        out_full   = 1'b1;
        #1;
        n_cmp++;
        if (frame_count !== 16'd0) begin
            n_err++; $display("FAIL rst_frame_count got %h want 0000", frame_count);
        end
        n_cmp++;
        if (last_total !== 32'd0) begin
            n_err++; $display("FAIL rst_last_total got %h want 00000000", last_total);
        end
        n_cmp++;
        if (proto_err !== 1'b0) begin
            n_err++; $display("FAIL rst_proto_err got %b want 0", proto_err);
        end
        out_full = 1'b0;
        #1;
        n_cmp++;
        if (out_wr_en !== 1'b1 || out_din !== 32'hA5A50000) begin
            n_err++; $display("FAIL rst_header got wr=%b %h want wr=1 a5a50000", out_wr_en, out_din);
        end
        do_reset();
    endtask

    task automatic test_directed();
        logic [31:0] want [4];
        int cyc;
        bit to;
        want = '{32'hA5A50000, 32'h00020001, 32'h00040003, 32'h5A5A0007};
        do_reset();
        queue_frame(16'd1, 16'd2, 16'd3, 16'd4, 16'd7);
        drain(0, cyc, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL directed_timeout got stuck want done"); end
        n_cmp++;
        if (got_q.size() !== 4) begin
            n_err++; $display("FAIL directed_len got %0d want 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== want[i]) begin
                n_err++; $display("FAIL directed_word%0d got %h want %h", i, got_q[i], want[i]);
            end
        end
        n_cmp++;
        if (frame_count !== 16'd1 || last_total !== 32'd10) begin
            n_err++; $display("FAIL directed_stats got fc=%h tot=%h want fc=0001 tot=0000000a",
                              frame_count, last_total);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit to;
        do_reset();
        queue_frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001);
        queue_frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0002);
        drain(0, cyc, to);
        n_cmp++;
        if (cyc !== 2 * (NB + 2) || to) begin
            n_err++; $display("FAIL b2b_cycles got %0d want %0d", cyc, 2 * (NB + 2));
        end
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL b2b_len got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL b2b_word%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (got_q.size() > 4 && got_q[4] !== 32'hA5A50001) begin
            n_err++; $display("FAIL b2b_hdr2 got %h want a5a50001", got_q[4]);
        end
        n_cmp++;
        if (last_total !== 32'h0003FFFC || frame_count !== m_fc) begin
            n_err++; $display("FAIL b2b_stats got tot=%h fc=%h want tot=0003fffc fc=%h",
                              last_total, frame_count, m_fc);
        end
    endtask

    task automatic test_stall();
        int cyc;
        bit to;
        do_reset();
        queue_frame(16'd10, 16'd20, 16'd30, 16'd40, 16'h00AB);
        step(1'b0, 1'b0);   // header
        step(1'b0, 1'b0);   // low bin into lo_q, now waiting on high bin
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            n_cmp++;
            if (obs_ffn !== 1'b0 || obs_wr !== 1'b0) begin
                n_err++; $display("FAIL stall_cyc%0d got full_n=%b wr=%b want 0 0", i, obs_ffn, obs_wr);
            end
        end
        drain(0, cyc, to);
        n_cmp++;
        if (got_q.size() !== exp_q.size() || to) begin
            n_err++; $display("FAIL stall_len got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL stall_word%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (last_total !== 32'd100) begin
            n_err++; $display("FAIL stall_total got %h want 00000064", last_total);
        end
    endtask

    task automatic test_random();
        int cyc;
        bit to;
        do_reset();
        wr_while_full = 0;
        for (int f = 0; f < 6; f++) begin
            queue_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                        16'($urandom));
        end
        drain(35, cyc, to);
        n_cmp++;
        if (got_q.size() !== exp_q.size() || to) begin
            n_err++; $display("FAIL rand_len got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL rand_word%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (frame_count !== 16'd6 || last_total !== m_total) begin
            n_err++; $display("FAIL rand_stats got fc=%h tot=%h want fc=0006 tot=%h",
                              frame_count, last_total, m_total);
        end
        n_cmp++;
        if (wr_while_full !== 0) begin
            n_err++; $display("FAIL rand_wr_full got %0d want 0", wr_while_full);
        end
    endtask

    task automatic test_proto();
        int cyc;
        bit to;
        logic [15:0] md;
        do_reset();
        queue_frame(16'd1, 16'd2, 16'd3, 16'd4, 16'd9);
        md = mode_q.pop_back();
        drain(0, cyc, to);
        step(1'b0, 1'b1);   // bin strobe while waiting for the mode
        n_cmp++;
        if (obs_wr !== 1'b0 || obs_ffn !== 1'b0) begin
            n_err++; $display("FAIL proto_ignored got wr=%b full_n=%b want 0 0", obs_wr, obs_ffn);
        end
        step(1'b1, 1'b0);
        n_cmp++;
        if (proto_err !== 1'b1) begin
            n_err++; $display("FAIL proto_set got %b want 1", proto_err);
        end
        mode_q.push_back(md);
        drain(0, cyc, to);
        n_cmp++;
        if (got_q.size() !== exp_q.size() || to) begin
            n_err++; $display("FAIL proto_len got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL proto_word%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (proto_err !== 1'b1 || last_total !== 32'd10) begin
            n_err++; $display("FAIL proto_sticky got err=%b tot=%h want 1 0000000a",
                              proto_err, last_total);
        end
        do_reset();
        #1;
        n_cmp++;
        if (proto_err !== 1'b0) begin
            n_err++; $display("FAIL proto_clear got %b want 0", proto_err);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        do_reset();
        queue_frame(16'd5, 16'd6, 16'd7, 16'd8, 16'd3);
        guard = 0;
        while (bins_acc < 3 && guard < 50) begin
            step(1'b0, 1'b0);
            guard++;
        end
        n_cmp++;
        if (bins_acc !== 3 || got_q.size() !== 2) begin
            n_err++; $display("FAIL mid_pre got bins=%0d words=%0d want 3 2", bins_acc, got_q.size());
        end
        @(negedge ap_clk);
        ap_rst     = 1'b1;
        freq_write = 1'b1;
        out_full   = 1'b0;
        #1;
        n_cmp++;
        if (out_wr_en !== 1'b0 || freq_full_n !== 1'b0) begin
            n_err++; $display("FAIL mid_rst got wr=%b full_n=%b want 0 0", out_wr_en, freq_full_n);
        end
        @(negedge ap_clk);
        ap_rst     = 1'b0;
        freq_write = 1'b0;
        #1;
        n_cmp++;
        if (out_wr_en !== 1'b1 || out_din !== 32'hA5A50000) begin
            n_err++; $display("FAIL mid_next got wr=%b %h want wr=1 a5a50000", out_wr_en, out_din);
        end
        n_cmp++;
        if (frame_count !== 16'd0 || last_total !== 32'd0) begin
            n_err++; $display("FAIL mid_stats got fc=%h tot=%h want 0 0", frame_count, last_total);
        end
        do_reset();
    endtask

    task automatic test_wrap();
        int cyc;
        bit to;
        do_reset();
        force dut.frame_count_q = 16'hFFFF;
        @(negedge ap_clk);
        release dut.frame_count_q;
        m_fc = 16'hFFFF;
        queue_frame(16'd100, 16'd200, 16'd300, 16'd400, 16'h0042);
        drain(0, cyc, to);
        n_cmp++;
        if (got_q.size() === 0 || got_q[0] !== 32'hA5A5FFFF || to) begin
            n_err++; $display("FAIL wrap_hdr got %h want a5a5ffff",
                              (got_q.size() != 0) ? got_q[0] : 32'hx);
        end
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL wrap_len got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL wrap_word%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (frame_count !== 16'd0 || last_total !== 32'd1000) begin
            n_err++; $display("FAIL wrap_stats got fc=%h tot=%h want 0000 000003e8",
                              frame_count, last_total);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ap_rst        = 1'b1;
        freq_din      = '0;
        freq_write    = 1'b0;
        mode_din      = '0;
        mode_write    = 1'b0;
        out_full      = 1'b0;
        m_fc          = '0;
        m_total       = '0;
        bins_acc      = 0;
        wr_while_full = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_random();
        test_proto();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
